// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll engine: the FSM state enum,
// the craps comparison constants, the LFSR tap mask and the per-die seed helper.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TUMBLE = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } dice_state_e;

    // Craps comparison values. These are fixed numbers for every die configuration.
    localparam int CRAPS_NAT7   = 7;
    localparam int CRAPS_NAT11  = 11;
    localparam int CRAPS_LOSE2  = 2;
    localparam int CRAPS_LOSE3  = 3;
    localparam int CRAPS_LOSE12 = 12;

    // Taps 16,14,13,11 in the right-shifting form map to state bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    // Die k is seeded with SEED ^ (SEED_OFFSET * (k+1)).
    localparam logic [15:0] SEED_OFFSET = 16'h1F35;

    // Seed for die k. An all-zero LFSR would lock up, so zero is replaced by 1.
    function automatic logic [15:0] die_seed(input logic [15:0] seed, input int k);
        logic [15:0] s;
        s = seed ^ 16'(SEED_OFFSET * 16'(k + 1));
        if (s == 16'h0000) begin
            s = 16'h0001;
        end
        return s;
    endfunction

    // One step of the 16-bit Fibonacci LFSR: shift right, feedback enters at bit 15.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {^(l & LFSR_TAP_MASK), l[15:1]};
    endfunction

endpackage

// File: rtl/dice_die_gen.sv
// One die: a 16-bit LFSR plus a 1..SIDES wrap counter. While en_i is high the
// LFSR steps every cycle and the die value advances whenever LFSR bit 0 is 1.
module dice_die_gen
    import dice_pkg::*;
#(
    parameter int          SIDES     = 6,
    parameter int          DIE_W     = 3,
    parameter logic [15:0] SEED_INIT = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [DIE_W-1:0] die_o
);

    logic [15:0]      lfsr_q, lfsr_d;
    logic [DIE_W-1:0] die_q, die_d;

    // Next-state: step LFSR and conditionally advance the face while tumbling.
    always_comb begin
        lfsr_d = lfsr_q;
        die_d  = die_q;
        if (en_i) begin
            lfsr_d = lfsr_next(lfsr_q);
            if (lfsr_q[0]) begin
                die_d = (die_q == DIE_W'(SIDES)) ? DIE_W'(1) : die_q + DIE_W'(1);
            end
        end
    end

    // State registers; reset reloads the seed and shows face 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED_INIT;
            die_q  <= DIE_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
            die_q  <= die_d;
        end
    end

    assign die_o = die_q;

endmodule

// File: rtl/dice_roll_engine.sv
// Dice roll engine: NUM_DICE dice of SIDES faces rolled by a request/done
// handshake, with registered sum, point register, craps flags and point compare.
// Optional feature: define DICE_ROLL_CNT_EN to build the saturating roll counter;
// otherwise roll_cnt is tied to zero.
//
// Handshake: roll_req is a one-cycle request sampled on the clock edge while
// busy is low and the engine is idle; requests during TUMBLE, SETTLE or DONE
// are dropped. roll_done pulses for exactly one cycle, TUMBLE_CYC+2 cycles
// after the request, when die_vals, sum and all flags are final.
module dice_roll_engine
    import dice_pkg::*;
#(
    parameter int          NUM_DICE   = 2,
    parameter int          SIDES      = 6,
    parameter int          DIE_W      = 3,
    parameter int          SUM_W      = 4,
    parameter int          TUMBLE_CYC = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      roll_req,
    input  logic                      sp,
    input  logic                      clr_point,
    output logic                      busy,
    output logic                      roll_done,
    output logic [NUM_DICE*DIE_W-1:0] die_vals,
    output logic [SUM_W-1:0]          sum,
    output logic [SUM_W-1:0]          point,
    output logic                      point_vld,
    output logic                      d7,
    output logic                      d711,
    output logic                      d2312,
    output logic                      eq,
    output logic [7:0]                roll_cnt
);

    localparam int CNT_W = (TUMBLE_CYC > 1) ? $clog2(TUMBLE_CYC) : 1;

    dice_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tumble_en;

    logic [SUM_W-1:0] dice_sum;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] point_q, point_d;
    logic             point_vld_q, point_vld_d;
    logic             d7_q, d7_d;
    logic             d711_q, d711_d;
    logic             d2312_q, d2312_d;
    logic             eq_q, eq_d;

    // Dice generators, one per die, each with its own seed.
    for (genvar g = 0; g < NUM_DICE; g++) begin : g_die
        dice_die_gen #(
            .SIDES     (SIDES),
            .DIE_W     (DIE_W),
            .SEED_INIT (die_seed(SEED, g))
        ) u_die (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (tumble_en),
            .die_o  (die_vals[g*DIE_W +: DIE_W])
        );
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        roll_done = 1'b0;
        tumble_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (roll_req) begin
                    state_d = TUMBLE;
                    cnt_d   = '0;
                end
            end
            TUMBLE: begin
                busy      = 1'b1;
                tumble_en = 1'b1;
                if (cnt_q == CNT_W'(TUMBLE_CYC - 1)) begin
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                roll_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and tumble cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Zero-extended sum of all dice; parameters guarantee it fits SUM_W.
    always_comb begin
        dice_sum = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            dice_sum = dice_sum + SUM_W'(die_vals[i*DIE_W +: DIE_W]);
        end
    end

    // Datapath next-state: sum and craps flags load together on the SETTLE edge so
    // they are final during DONE; point updates from sp/clr_point; eq follows both.
    always_comb begin
        sum_d       = sum_q;
        d7_d        = d7_q;
        d711_d      = d711_q;
        d2312_d     = d2312_q;
        point_d     = point_q;
        point_vld_d = point_vld_q;
        if (state_q == SETTLE) begin
            sum_d   = dice_sum;
            d7_d    = (32'(dice_sum) == CRAPS_NAT7);
            d711_d  = (32'(dice_sum) == CRAPS_NAT7) || (32'(dice_sum) == CRAPS_NAT11);
            d2312_d = (32'(dice_sum) == CRAPS_LOSE2) || (32'(dice_sum) == CRAPS_LOSE3) ||
                      (32'(dice_sum) == CRAPS_LOSE12);
        end
        // clr_point works in any state and wins; sp captures the pre-roll sum in IDLE.
        if (clr_point) begin
            point_d     = '0;
            point_vld_d = 1'b0;
        end else if (sp && state_q == IDLE) begin
            point_d     = sum_q;
            point_vld_d = 1'b1;
        end
        eq_d = point_vld_d && (sum_d == point_d);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q       <= '0;
            point_q     <= '0;
            point_vld_q <= 1'b0;
            d7_q        <= 1'b0;
            d711_q      <= 1'b0;
            d2312_q     <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            point_q     <= point_d;
            point_vld_q <= point_vld_d;
            d7_q        <= d7_d;
            d711_q      <= d711_d;
            d2312_q     <= d2312_d;
            eq_q        <= eq_d;
        end
    end

    assign sum       = sum_q;
    assign point     = point_q;
    assign point_vld = point_vld_q;
    assign d7        = d7_q;
    assign d711      = d711_q;
    assign d2312     = d2312_q;
    assign eq        = eq_q;

`ifdef DICE_ROLL_CNT_EN
    logic [7:0] roll_cnt_q, roll_cnt_d;

    // Completed-roll counter, saturating at 255; cleared only by reset.
    always_comb begin
        roll_cnt_d = roll_cnt_q;
        if (state_q == DONE && roll_cnt_q != 8'hFF) begin
            roll_cnt_d = roll_cnt_q + 8'd1;
        end
    end

    // Roll counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            roll_cnt_q <= 8'd0;
        end else begin
            roll_cnt_q <= roll_cnt_d;
        end
    end

    assign roll_cnt = roll_cnt_q;
`else
    assign roll_cnt = 8'd0;
`endif

endmodule
